fizzbuzz_sched: RTL and testbench

Run controller for the fizz/buzz classification datapath. It accepts a runtime configuration (fizz divisor, buzz divisor, run length) through a valid/ready port and, on `start`, sequences an index counter from 0 to length−1. Each index is classified with wrap-around residue counters rather than modulo arithmetic, and the result is streamed out on a valid/ready port that supports backpressure. It sits between a host/config agent and any consumer of the fizz/buzz stream, and replaces the free-running modulo counter wherever run control, stalls or reconfiguration are needed.

---
 rtl/fizzbuzz_pkg.sv | 27 ++
 rtl/fizzbuzz_mod_counter.sv | 38 +++
 rtl/fizzbuzz_sched.sv | 161 ++++++++++++++++
 tb/tb_fizzbuzz_sched.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fizzbuzz_pkg.sv
// Shared types and constants for the fizz/buzz run controller.
//   fb_state_t  : controller states (idle, streaming a run, completion pulse)
//   fb_code_t   : beat classification, bit 0 = fizz hit, bit 1 = buzz hit
//   FB_DIV_MIN  : smallest legal divisor; a zero divisor is stored as this
//   fb_classify : packs the two residue hits into a classification code
package fizzbuzz_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fb_state_t;

  typedef enum logic [1:0] {
    CODE_NONE     = 2'd0,
    CODE_FIZZ     = 2'd1,
    CODE_BUZZ     = 2'd2,
    CODE_FIZZBUZZ = 2'd3
  } fb_code_t;

  localparam int unsigned FB_DIV_MIN = 32'd1;

  function automatic fb_code_t fb_classify(input logic fizz_hit, input logic buzz_hit);
    return fb_code_t'({buzz_hit, fizz_hit});
  endfunction

endpackage

// File: rtl/fizzbuzz_mod_counter.sv
// Wrap-around residue counter.
//   clk, resetn : clock and asynchronous active-low reset
//   clr         : synchronous clear to 0 (wins over inc)
//   inc         : advance by one, wrapping to 0 once modulus-1 is reached
//   modulus     : wrap modulus, expected >= 1
//   value       : current residue
module mod_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             inc,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] r_value;
  logic [WIDTH-1:0] w_top;

  assign w_top = modulus - WIDTH'(1);

  // Residue register; >= instead of == keeps it bounded if modulus ever shrinks.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_value <= '0;
    end else if (clr) begin
      r_value <= '0;
    end else if (inc) begin
      r_value <= (r_value >= w_top) ? '0 : (r_value + WIDTH'(1));
    end else begin
      r_value <= r_value;
    end
  end

  assign value = r_value;

endmodule

// File: rtl/fizzbuzz_sched.sv
// Fizz/buzz run controller.
//   cfg_valid/cfg_ready/cfg_fizz/cfg_buzz/cfg_len : configuration port, open only in IDLE
//   start / abort : begin a run (IDLE only) / terminate a run (RUN only)
//   busy          : controller not idle
//   out_valid/out_ready/out_idx/out_code : classification stream with backpressure
//   done          : one-cycle pulse after the last beat of a completed run
// All outputs decode registered state; out_ready never reaches out_valid combinationally.
module fizzbuzz_sched
  import fizzbuzz_pkg::*;
#(
  parameter int unsigned FIZZ       = 3,
  parameter int unsigned BUZZ       = 5,
  parameter int unsigned MAX_CYCLES = 100,
  parameter int unsigned DIV_W      = 8,
  parameter int unsigned CNT_W      = $clog2(MAX_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_fizz,
  input  logic [DIV_W-1:0] cfg_buzz,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_idx,
  output logic [1:0]       out_code,
  output logic             done
);

  localparam logic [DIV_W-1:0] L_FIZZ    = DIV_W'(FIZZ);
  localparam logic [DIV_W-1:0] L_BUZZ    = DIV_W'(BUZZ);
  localparam logic [DIV_W-1:0] L_DIV_MIN = DIV_W'(FB_DIV_MIN);
  localparam logic [CNT_W-1:0] L_MAX_LEN = CNT_W'(MAX_CYCLES);

  fb_state_t        r_state;
  fb_state_t        w_state_nxt;
  logic [DIV_W-1:0] r_fizz;
  logic [DIV_W-1:0] r_buzz;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_idx;
  logic [DIV_W-1:0] w_fizz_res;
  logic [DIV_W-1:0] w_buzz_res;
  logic [DIV_W-1:0] w_fizz_in;
  logic [DIV_W-1:0] w_buzz_in;
  logic [CNT_W-1:0] w_len_in;
  logic [CNT_W-1:0] w_len_eff;
  logic             w_cfg_take;
  logic             w_start_go;
  logic             w_xfer;
  logic             w_last;
  fb_code_t         w_code;

  // Config is only accepted while idle; clamp divisors to >= 1 and length to MAX_CYCLES.
  assign w_cfg_take = cfg_valid && (r_state == S_IDLE);
  assign w_fizz_in  = (cfg_fizz == {DIV_W{1'b0}}) ? L_DIV_MIN : cfg_fizz;
  assign w_buzz_in  = (cfg_buzz == {DIV_W{1'b0}}) ? L_DIV_MIN : cfg_buzz;
  assign w_len_in   = (cfg_len > L_MAX_LEN) ? L_MAX_LEN : cfg_len;
  // A config arriving with start governs that very run.
  assign w_len_eff  = w_cfg_take ? w_len_in : r_len;

  assign w_start_go = (r_state == S_IDLE) && start;
  assign w_xfer     = (r_state == S_RUN) && out_ready;
  assign w_last     = (r_idx == (r_len - CNT_W'(1)));

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort outranks a simultaneous final transfer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (w_len_eff == {CNT_W{1'b0}}) ? S_DONE : S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_xfer && w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stored run configuration.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fizz <= L_FIZZ;
      r_buzz <= L_BUZZ;
      r_len  <= L_MAX_LEN;
    end else if (w_cfg_take) begin
      r_fizz <= w_fizz_in;
      r_buzz <= w_buzz_in;
      r_len  <= w_len_in;
    end else begin
      r_fizz <= r_fizz;
      r_buzz <= r_buzz;
      r_len  <= r_len;
    end
  end

  // Beat index: cleared on start, advanced per accepted beat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_idx <= '0;
    end else if (w_start_go) begin
      r_idx <= '0;
    end else if (w_xfer) begin
      r_idx <= r_idx + CNT_W'(1);
    end else begin
      r_idx <= r_idx;
    end
  end

  mod_counter #(.WIDTH(DIV_W)) u_fizz_res (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (w_start_go),
    .inc     (w_xfer),
    .modulus (r_fizz),
    .value   (w_fizz_res)
  );

  mod_counter #(.WIDTH(DIV_W)) u_buzz_res (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (w_start_go),
    .inc     (w_xfer),
    .modulus (r_buzz),
    .value   (w_buzz_res)
  );

  assign w_code = fb_classify((w_fizz_res == {DIV_W{1'b0}}), (w_buzz_res == {DIV_W{1'b0}}));

  // Code is forced to NONE outside RUN so idle outputs read as zero.
  assign out_valid = (r_state == S_RUN);
  assign out_code  = (r_state == S_RUN) ? w_code : CODE_NONE;
  assign out_idx   = r_idx;
  assign busy      = (r_state != S_IDLE);
  assign cfg_ready = (r_state == S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_fizzbuzz_sched.sv
module tb_fizzbuzz_sched;

  localparam int MAXC  = 100;
  localparam int CNT_W = $clog2(MAXC + 1);

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [7:0]       cfg_fizz = 8'd0;
  logic [7:0]       cfg_buzz = 8'd0;
  logic [CNT_W-1:0] cfg_len = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             busy;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] out_idx;
  logic [1:0]       out_code;
  logic             done;

  int n_checks = 0;
  int n_errors = 0;

  // reference model of the stored configuration
  int m_fizz = 3;
  int m_buzz = 5;
  int m_len  = MAXC;

  always #5 clk = ~clk;

  fizzbuzz_sched dut (
    .clk(clk), .resetn(resetn),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_fizz(cfg_fizz), .cfg_buzz(cfg_buzz), .cfg_len(cfg_len),
    .start(start), .abort(abort), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_code(out_code), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_code(input int i);
    logic [31:0] c;
    c = 32'd0;
    if ((i % m_fizz) == 0) c = c + 32'd1;
    if ((i % m_buzz) == 0) c = c + 32'd2;
    return c;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cfg_ready"}, cfg_ready, 1);
  endtask

  // One run from IDLE. stall_pct < 0 selects the ready pattern 1,0,0,1,0,0...
  // abort_at >= 0 aborts while that index is presented.
  task automatic do_run(input int fz, input int bz, input int ln, input bit send_cfg,
                        input int stall_pct, input int abort_at, input bit noise);
    logic [CNT_W-1:0] ln_t;
    int exp_idx, cyc, stalls, k;
    bit aborted;
    ln_t = CNT_W'(ln);
    if (send_cfg) begin
      m_fizz = (fz == 0) ? 1 : fz;
      m_buzz = (bz == 0) ? 1 : bz;
      m_len  = (int'(ln_t) > MAXC) ? MAXC : int'(ln_t);
    end
    cfg_valid = send_cfg;
    cfg_fizz  = 8'(fz);
    cfg_buzz  = 8'(bz);
    cfg_len   = ln_t;
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    start     = 1'b0;
    exp_idx = 0; cyc = 1; stalls = 0; k = 0; aborted = 1'b0;
    while (exp_idx < m_len && cyc < 4000) begin
      chk("beat_valid", out_valid, 1);
      chk("beat_idx", out_idx, exp_idx);
      chk("beat_code", out_code, ref_code(exp_idx));
      chk("beat_busy", busy, 1);
      chk("beat_cfg_ready", cfg_ready, 0);
      chk("beat_done", done, 0);
      if (exp_idx == abort_at) begin
        abort = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        chk("abort_no_done", done, 0);
        aborted = 1'b1;
        break;
      end
      if (noise) begin
        cfg_valid = 1'b1;
        cfg_fizz  = 8'($urandom_range(9, 2));
        cfg_buzz  = 8'($urandom_range(9, 2));
        cfg_len   = CNT_W'($urandom_range(20, 1));
      end
      if (stall_pct < 0) out_ready = ((k % 3) == 0);
      else               out_ready = ($urandom_range(99) >= stall_pct);
      k++;
      if (out_ready) exp_idx++;
      else           stalls++;
      @(negedge clk);
      cyc++;
    end
    cfg_valid = 1'b0;
    if (cyc >= 4000) chk("run_timeout", cyc, 0);
    if (!aborted) begin
      chk("done_pulse", done, 1);
      chk("done_valid", out_valid, 0);
      chk("done_cycle", cyc, m_len + stalls + 1);
      @(negedge clk);
      chk_idle("after_done");
    end
  endtask

  initial begin
    #12;
    chk_idle("reset");
    chk("reset_idx", out_idx, 0);
    chk("reset_code", out_code, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // defaults 3/5/100
    do_run(0, 0, 0, 1'b0, 0, -1, 1'b0);
    // config with start in the same cycle
    do_run(2, 3, 7, 1'b1, 0, -1, 1'b0);
    // stall pattern 1,0,0,1 with len 4
    do_run(3, 5, 4, 1'b1, -1, -1, 1'b0);
    // edge config values, largest encodable length clamps to MAX_CYCLES; cfg during RUN ignored
    do_run(0, 1, 127, 1'b1, 0, -1, 1'b1);
    // stored config survived the noise
    do_run(0, 0, 0, 1'b0, 20, -1, 1'b0);
    // abort at idx 5, then restart
    do_run(3, 5, 10, 1'b1, 0, 5, 1'b0);
    do_run(0, 0, 0, 1'b0, 0, -1, 1'b0);
    // length 0
    do_run(4, 6, 0, 1'b1, 0, -1, 1'b0);
    // randomized runs
    for (int r = 0; r < 8; r++) begin
      do_run($urandom_range(9), $urandom_range(9), $urandom_range(127),
             1'($urandom_range(1)), $urandom_range(60), -1, 1'b0);
    end

    // mid-run asynchronous reset
    cfg_valid = 1'b1; cfg_fizz = 8'd4; cfg_buzz = 8'd7; cfg_len = CNT_W'(20);
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_valid", out_valid, 1);
    #2 resetn = 1'b0;
    #1;
    chk("async_reset_valid", out_valid, 0);
    chk("async_reset_busy", busy, 0);
    @(negedge clk);
    resetn = 1'b1;
    m_fizz = 3; m_buzz = 5; m_len = MAXC;
    chk_idle("post_reset");
    @(negedge clk);
    do_run(0, 0, 0, 1'b0, 10, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
